// File: rtl/hc574_bank_arbiter.sv
// rtl/hc574_bank_arbiter.sv - round-robin arbiter and bus sequencer for a bank of HC574CLK latches
module hc574_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int NLATCH = 4,
  parameter int SELW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*SELW-1:0] req_sel,
  input  logic [NREQ*8-1:0]    req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic [7:0]           bus_dout,
  output logic                 bus_drive,
  input  logic [7:0]           bus_din,
  output logic [NLATCH-1:0]    le,
  output logic [NLATCH-1:0]    oe_dis
);

  localparam int PTRW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_ENABLE, R_SAMPLE, TURN
  } state_t;

  state_t            state, state_d;
  logic [PTRW-1:0]   ptr, ptr_d;
  logic [SELW-1:0]   cap_sel, sel_d;
  logic [7:0]        cap_wdata, wdata_d;
  logic [NREQ-1:0]   gnt_d;
  logic [7:0]        rdata_d, bus_dout_d;
  logic              bus_drive_d, busy_d;
  logic [NLATCH-1:0] le_d, oe_dis_d;
  logic              found;
  logic [PTRW-1:0]   win, idx;

  logic [SELW-1:0] sel_arr   [NREQ];
  logic [7:0]      wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign sel_arr[g]   = req_sel[g*SELW +: SELW];
    assign wdata_arr[g] = req_wdata[g*8 +: 8];
  end

  // Out-of-range selects decode to all zeros, so no latch is touched.
  function automatic logic [NLATCH-1:0] decode(input logic [SELW-1:0] s);
    logic [NLATCH-1:0] d;
    d = '0;
    for (int k = 0; k < NLATCH; k++) begin
      if (s == SELW'(k)) d[k] = 1'b1;
    end
    return d;
  endfunction

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PTRW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    sel_d       = cap_sel;
    wdata_d     = cap_wdata;
    gnt_d       = '0;
    rdata_d     = rdata;
    bus_dout_d  = bus_dout;
    bus_drive_d = 1'b0;
    le_d        = '0;
    oe_dis_d    = '1;
    case (state)
      IDLE: begin
        if (found) begin
          ptr_d   = win;
          sel_d   = sel_arr[win];
          wdata_d = wdata_arr[win];
          if (req_we[win]) begin
            state_d     = W_SETUP;
            bus_drive_d = 1'b1;
            bus_dout_d  = wdata_arr[win];
          end else begin
            state_d  = R_ENABLE;
            oe_dis_d = ~decode(sel_arr[win]);
          end
        end
      end
      W_SETUP: begin
        state_d     = W_STROBE;
        bus_drive_d = 1'b1;
        le_d        = decode(cap_sel);
      end
      W_STROBE: begin
        state_d     = W_HOLD;
        bus_drive_d = 1'b1;
        le_d        = decode(cap_sel);
      end
      W_HOLD: begin
        state_d    = TURN;
        gnt_d[ptr] = 1'b1;
      end
      R_ENABLE: begin
        state_d  = R_SAMPLE;
        oe_dis_d = ~decode(cap_sel);
      end
      R_SAMPLE: begin
        state_d    = TURN;
        gnt_d[ptr] = 1'b1;
        rdata_d    = (|decode(cap_sel)) ? bus_din : 8'hFF;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PTRW'(NREQ - 1);
      cap_sel   <= '0;
      cap_wdata <= '0;
      gnt       <= '0;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      bus_dout  <= 8'h00;
      bus_drive <= 1'b0;
      le        <= '0;
      oe_dis    <= '1;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cap_sel   <= sel_d;
      cap_wdata <= wdata_d;
      gnt       <= gnt_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
      bus_dout  <= bus_dout_d;
      bus_drive <= bus_drive_d;
      le        <= le_d;
      oe_dis    <= oe_dis_d;
    end
  end

endmodule

// File: tb/tb_hc574_bank_arbiter.sv
// tb/tb_hc574_bank_arbiter.sv - directed table-driven bench with an HC574CLK bank model
module tb_hc574_bank_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req, req_we;
  logic [7:0]  req_sel;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [7:0]  rdata, bus_dout, bus_din;
  logic        busy, bus_drive;
  logic [3:0]  le, oe_dis;

  logic [3:0]  req3, req_we3;
  logic [7:0]  req_sel3;
  logic [31:0] req_wdata3;
  logic [3:0]  gnt3;
  logic [7:0]  rdata3, bus_dout3, bus_din3;
  logic        busy3, bus_drive3;
  logic [2:0]  le3, oe_dis3;

  hc574_bank_arbiter #(.NREQ(4), .NLATCH(4), .SELW(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_sel(req_sel),
    .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata), .busy(busy),
    .bus_dout(bus_dout), .bus_drive(bus_drive), .bus_din(bus_din),
    .le(le), .oe_dis(oe_dis)
  );

  hc574_bank_arbiter #(.NREQ(4), .NLATCH(3), .SELW(2)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_we(req_we3), .req_sel(req_sel3),
    .req_wdata(req_wdata3), .gnt(gnt3), .rdata(rdata3), .busy(busy3),
    .bus_dout(bus_dout3), .bus_drive(bus_drive3), .bus_din(bus_din3),
    .le(le3), .oe_dis(oe_dis3)
  );

  // Latch model: captures on a clk-sampled le rising edge confirmed for two samples.
  logic [7:0] lat_q [4] = '{default: 8'h00};
  logic [3:0] s1 = 4'h0, s2 = 4'h0;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      s1[k] <= le[k];
      s2[k] <= s1[k];
      if (le[k] && s1[k] && !s2[k]) lat_q[k] <= bus_din;
    end
  end

  always_comb begin
    bus_din = bus_drive ? bus_dout : 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (!oe_dis[k]) bus_din = lat_q[k];
    end
  end

  int n_viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_drive && !(&oe_dis)) n_viol++;
      if ($countones(le) > 1) n_viol++;
      if ($countones(~oe_dis) > 1) n_viol++;
      if ($countones(le3) > 1 || $countones(~oe_dis3) > 1) n_viol++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] r, input logic we, input logic [1:0] sel,
                         input logic [7:0] wd);
    req_we[r]                  = we;
    req_sel[{r, 1'b0} +: 2]    = sel;
    req_wdata[{r, 3'b000} +: 8] = wd;
    req[r]                     = 1'b1;
  endtask

  typedef struct {
    logic [1:0] r;
    logic       we;
    logic [1:0] sel;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int         gnt_at, w_at, r_at, n;
    logic [3:0] gnt_val, oh, gsum;
    logic [5:0] drv_tr, busy_tr, oe3_tr;
    logic [15:0] le_tr;
    logic [11:0] oe_tr;
    logic [23:0] dout_tr;
    logic [7:0] rd;
    logic [3:0] gseq [8];
    logic [7:0] rdseq [8];

    tbl[0] = '{2'd0, 1'b1, 2'd2, 8'hA5, 8'hA5};
    tbl[1] = '{2'd3, 1'b1, 2'd1, 8'h3C, 8'h3C};
    tbl[2] = '{2'd1, 1'b0, 2'd1, 8'h00, 8'h3C};
    tbl[3] = '{2'd2, 1'b1, 2'd0, 8'h5A, 8'h5A};
    tbl[4] = '{2'd3, 1'b0, 2'd0, 8'h00, 8'h5A};
    tbl[5] = '{2'd0, 1'b0, 2'd2, 8'h00, 8'hA5};
    tbl[6] = '{2'd2, 1'b1, 2'd3, 8'hC3, 8'hC3};
    tbl[7] = '{2'd1, 1'b0, 2'd3, 8'h00, 8'hC3};

    req = '0; req_we = '0; req_sel = '0; req_wdata = '0;
    req3 = '0; req_we3 = '0; req_sel3 = '0; req_wdata3 = '0;
    bus_din3 = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_gnt", gnt, 4'h0);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_bus_dout", bus_dout, 8'h00);
    chk("reset_bus_drive", bus_drive, 1'b0);
    chk("reset_le", le, 4'h0);
    chk("reset_oe_dis", oe_dis, 4'hF);

    // Simultaneous write (req 0) and read (req 1) of latch 0 straight after reset.
    @(negedge clk);
    set_req(2'd0, 1'b1, 2'd0, 8'h5A);
    set_req(2'd1, 1'b0, 2'd0, 8'h00);
    w_at = 0; r_at = 0; rd = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt[0] && w_at == 0) begin w_at = c; req[0] = 1'b0; end
      if (gnt[1] && r_at == 0) begin r_at = c; req[1] = 1'b0; rd = rdata; end
    end
    chk("wr_rd_write_gnt_cycle", w_at, 4);
    chk("wr_rd_read_gnt_cycle", r_at, 8);
    chk("wr_rd_rdata", rd, 8'h5A);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      set_req(tbl[v].r, tbl[v].we, tbl[v].sel, tbl[v].wd);
      oh = 4'b0001 << tbl[v].sel;
      gnt_at = 0; gnt_val = '0; rd = 8'h00;
      drv_tr = '0; busy_tr = '0; le_tr = '0; oe_tr = '0; dout_tr = '0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        drv_tr[c-1]  = bus_drive;
        busy_tr[c-1] = busy;
        if (c <= 4) le_tr[(4-c)*4 +: 4] = le;
        if (c <= 3) begin
          oe_tr[(3-c)*4 +: 4]   = oe_dis;
          dout_tr[(3-c)*8 +: 8] = bus_dout;
        end
        if (gnt != 4'h0 && gnt_at == 0) begin
          gnt_at = c; gnt_val = gnt; rd = rdata; req[tbl[v].r] = 1'b0;
        end
      end
      chk($sformatf("vec%0d_gnt_value", v), gnt_val, 4'b0001 << tbl[v].r);
      if (tbl[v].we) begin
        chk($sformatf("vec%0d_w_gnt_cycle", v), gnt_at, 4);
        chk($sformatf("vec%0d_w_bus_drive", v), drv_tr, 6'b000111);
        chk($sformatf("vec%0d_w_busy", v), busy_tr, 6'b001111);
        chk($sformatf("vec%0d_w_bus_dout", v), dout_tr, {3{tbl[v].wd}});
        chk($sformatf("vec%0d_w_le", v), le_tr, {4'h0, oh, oh, 4'h0});
        chk($sformatf("vec%0d_w_latch", v), lat_q[tbl[v].sel], tbl[v].exp);
      end else begin
        chk($sformatf("vec%0d_r_gnt_cycle", v), gnt_at, 3);
        chk($sformatf("vec%0d_r_bus_drive", v), drv_tr, 6'b000000);
        chk($sformatf("vec%0d_r_busy", v), busy_tr, 6'b000111);
        chk($sformatf("vec%0d_r_oe_dis", v), oe_tr, {~oh, ~oh, 4'hF});
        chk($sformatf("vec%0d_r_rdata", v), rd, tbl[v].exp);
      end
    end

    // Reset in W_STROBE aborts the write; latch 2 keeps A5.
    @(negedge clk);
    set_req(2'd0, 1'b1, 2'd2, 8'h77);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b0;
    chk("abort_le", le, 4'h0);
    chk("abort_bus_drive", bus_drive, 1'b0);
    chk("abort_oe_dis", oe_dis, 4'hF);
    chk("abort_busy", busy, 1'b0);
    gsum = gnt;
    repeat (4) begin
      @(negedge clk);
      gsum |= gnt;
    end
    chk("abort_no_gnt", gsum, 4'h0);
    chk("abort_latch_kept", lat_q[2], 8'hA5);
    chk("abort_rdata", rdata, 8'h00);

    // All four requesting continuously, rotation from requester 0.
    @(negedge clk);
    set_req(2'd0, 1'b1, 2'd0, 8'h11);
    set_req(2'd1, 1'b0, 2'd0, 8'h00);
    set_req(2'd2, 1'b1, 2'd3, 8'h33);
    set_req(2'd3, 1'b0, 2'd3, 8'h00);
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (gnt != 4'h0) begin
        gseq[n] = gnt; rdseq[n] = rdata; n++;
      end
    end
    req = '0;
    chk("rot_grant_count", n, 8);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rot_grant%0d", i), gseq[i], 4'b0001 << (i % 4));
      if (i % 2 == 1)
        chk($sformatf("rot_rdata%0d", i), rdseq[i], (i % 4 == 1) ? 8'h11 : 8'h33);
    end
    repeat (6) @(negedge clk);

    // Out-of-range read on the three-latch instance.
    chk("nl3_reset_rdata", rdata3, 8'h00);
    @(negedge clk);
    req_we3[2] = 1'b0; req_sel3[5:4] = 2'd3; req3[2] = 1'b1;
    gnt_at = 0; gnt_val = '0; rd = 8'h00; oe3_tr = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 2) oe3_tr[(2-c)*3 +: 3] = oe_dis3;
      if (gnt3 != 4'h0 && gnt_at == 0) begin
        gnt_at = c; gnt_val = gnt3; rd = rdata3; req3[2] = 1'b0;
      end
    end
    chk("oor_oe_dis", oe3_tr, 6'b111111);
    chk("oor_gnt_cycle", gnt_at, 3);
    chk("oor_gnt_value", gnt_val, 4'b0100);
    chk("oor_rdata", rd, 8'hFF);

    chk("no_contention", n_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
